// File: rtl/btn_debounce_edge.sv
// btn_debounce_edge: synchronizes and debounces a raw button input, producing a
// clean level plus rise/fall pulses and a once-per-press long-hold pulse.
module btn_debounce_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int HOLD_CYCLES   = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic hold_pulse
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] S_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
    typedef enum logic [1:0] {LOW, TO_HIGH, HIGH, TO_LOW} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt, cnt_n;
    logic [HW-1:0] hold_cnt;
    logic level_n, rise_n, fall_n, s;
    assign s = sync[SYNC_STAGES-1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= '0;
            state      <= LOW;
            cnt        <= '0;
            btn_level  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], btn_in};
            state      <= state_n;
            cnt        <= cnt_n;
            btn_level  <= level_n;
            rise_pulse <= rise_n;
            fall_pulse <= fall_n;
        end
    end
    // A single-cycle debounce window skips the transitional states entirely.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = btn_level;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            LOW: if (s) begin
                if (STABLE_CYCLES == 1) begin
                    state_n = HIGH;
                    level_n = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    state_n = TO_HIGH;
                    cnt_n   = CW'(1);
                end
            end
            TO_HIGH: if (!s) begin
                state_n = LOW;
                cnt_n   = '0;
            end else if (cnt == S_LAST) begin
                state_n = HIGH;
                level_n = 1'b1;
                rise_n  = 1'b1;
                cnt_n   = '0;
            end else cnt_n = cnt + CW'(1);
            HIGH: if (!s) begin
                if (STABLE_CYCLES == 1) begin
                    state_n = LOW;
                    level_n = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    state_n = TO_LOW;
                    cnt_n   = CW'(1);
                end
            end
            TO_LOW: if (s) begin
                state_n = HIGH;
                cnt_n   = '0;
            end else if (cnt == S_LAST) begin
                state_n = LOW;
                level_n = 1'b0;
                fall_n  = 1'b1;
                cnt_n   = '0;
            end else cnt_n = cnt + CW'(1);
            default: state_n = LOW;
        endcase
    end
    // Hold count keeps running through TO_LOW bounces since btn_level is still high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt   <= '0;
            hold_pulse <= 1'b0;
        end else begin
            hold_cnt   <= !btn_level ? '0 : (hold_cnt == H_MAX ? hold_cnt : hold_cnt + HW'(1));
            hold_pulse <= btn_level && hold_cnt == H_LAST;
        end
    end
endmodule

// File: tb/tb_btn_debounce_edge.sv
// tb_btn_debounce_edge: directed and random stimulus against a run-length
// reference model of the debouncer.
module tb_btn_debounce_edge;
    localparam int SYNC = 2, STABLE = 4, HOLD = 10;
    logic clk = 0, rst = 1, btn_in = 1;
    logic btn_level, rise_pulse, fall_pulse, hold_pulse;
    int n_vec = 0, n_err = 0;
    int q[$];
    int run, held, cyc, first, n_rise, n_fall, n_hold, rise_cyc, hold_cyc, mark;
    bit m_lvl, m_rise, m_fall, m_hold;

    btn_debounce_edge #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .hold_pulse(hold_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q = {};
        for (int i = 0; i < SYNC; i++) q.push_back(0);
        run = 0; held = 0;
        m_lvl = 0; m_rise = 0; m_fall = 0; m_hold = 0;
    endtask

    // s seen by the logic is btn_in delayed SYNC edges; level flips after STABLE
    // consecutive disagreeing samples; hold counts edges spent with level high.
    task automatic model_edge();
        int s;
        s = q.pop_front();
        q.push_back(int'(btn_in));
        m_hold = 0;
        if (m_lvl) begin
            if (held < HOLD) begin
                held++;
                m_hold = (held == HOLD);
            end
        end else held = 0;
        m_rise = 0; m_fall = 0;
        if (s != int'(m_lvl)) begin
            run++;
            if (run == STABLE) begin
                m_lvl = bit'(s); m_rise = bit'(s); m_fall = !bit'(s); run = 0;
            end
        end else run = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".level"}, int'(btn_level), int'(m_lvl));
        chk({tag, ".rise"}, int'(rise_pulse), int'(m_rise));
        chk({tag, ".fall"}, int'(fall_pulse), int'(m_fall));
        chk({tag, ".hold"}, int'(hold_pulse), int'(m_hold));
    endtask

    task automatic step(input logic b, input string tag);
        btn_in = b;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk_all(tag);
        if (rise_pulse === 1'b1) begin n_rise++; rise_cyc = cyc; end
        if (fall_pulse === 1'b1) n_fall++;
        if (hold_pulse === 1'b1) begin n_hold++; hold_cyc = cyc; end
    endtask

    initial begin
        cyc = 0; n_rise = 0; n_fall = 0; n_hold = 0; rise_cyc = 0; hold_cyc = 0;
        model_reset();
        #1;
        chk_all("reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_all("reset_hold");
        end
        rst = 0;
        repeat (4) step(0, "idle");

        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1, "press");
            if (rise_pulse === 1'b1 && first == 0) first = i;
        end
        chk("press_latency", first, SYNC + STABLE);
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, "release");
            if (fall_pulse === 1'b1 && first == 0) first = i;
        end
        chk("release_latency", first, SYNC + STABLE);

        mark = n_rise;
        repeat (3) step(1, "bounce");
        step(0, "bounce");
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1, "bounce_settle");
            if (rise_pulse === 1'b1 && first == 0) first = i;
        end
        chk("bounce_latency", first, SYNC + STABLE);
        chk("bounce_rise_count", n_rise - mark, 1);

        mark = n_hold;
        repeat (10) step(1, "hold");
        chk("hold_count", n_hold - mark, 1);
        chk("hold_delay", hold_cyc - rise_cyc, HOLD);
        repeat (50) step(1, "hold_long");
        chk("hold_once", n_hold - mark, 1);
        mark = n_fall;
        repeat (10) step(0, "hold_release");
        chk("hold_fall_count", n_fall - mark, 1);

        repeat (4) step(1, "mid_press");
        rst = 1;
        model_reset();
        #1;
        chk_all("mid_reset");
        @(posedge clk);
        #1;
        chk_all("mid_reset_hold");
        rst = 0;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1, "post_reset");
            if (rise_pulse === 1'b1 && first == 0) first = i;
        end
        chk("post_reset_latency", first, SYNC + STABLE);
        repeat (10) step(0, "post_reset_release");

        mark = n_rise;
        step(1, "glitch1");
        repeat (8) step(0, "glitch1_gap");
        repeat (3) step(1, "glitch3");
        repeat (8) step(0, "glitch3_gap");
        chk("glitch_rises", n_rise - mark, 0);
        chk("glitch_level", int'(btn_level), 0);

        for (int seg = 0; seg < 120; seg++) begin
            logic v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
            repeat (len) step(v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
